// File: rtl/com_tx_scheduler.sv
// Round-robin merge of four byte requesters into a FIFO that feeds a UART transmitter; ack one cycle after grant.
// Grants stall while the FIFO is full; each byte is abandoned with timeout_err if the transmitter stalls TIMEOUT_CYC cycles.
module com_tx_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_finish,
    output logic [4:0]  fifo_count,
    output logic        busy,
    output logic        timeout_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [4:0]    DEPTH    = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic [1:0]      last_q, last_d;
    logic [3:0]      ack_q, ack_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            busy_q, busy_d;
    logic            tmo_q, tmo_d;
    logic            push, pop, timer_hit;
    logic [1:0]      win, idx;
    logic [3:0]      avail;

    // Requesters still showing their ack this cycle are masked so a held req is not taken twice.
    always_comb begin
        push  = 1'b0;
        win   = last_q;
        idx   = last_q;
        avail = req & ~ack_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!push && avail[idx] && (count_q < DEPTH)) begin
                push = 1'b1;
                win  = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        tmo_d      = 1'b0;
        pop        = 1'b0;
        timer_hit  = (timer_q >= TMO_LAST);
        case (state_q)
            IDLE: begin
                if ((count_q != 5'd0) && tx_finish) begin
                    pop        = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    timer_d    = '0;
                    state_d    = START;
                end
            end
            START: begin
                timer_d = (timer_q == TMO_MAX) ? timer_q : timer_q + TW'(1);
                if (timer_hit) begin
                    tx_start_d = 1'b0;
                    tmo_d      = 1'b1;
                    state_d    = IDLE;
                end else if (!tx_finish) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                timer_d = (timer_q == TMO_MAX) ? timer_q : timer_q + TW'(1);
                if (timer_hit) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else if (tx_finish) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        count_d  = count_q + 5'(push) - 5'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        ack_d    = push ? (4'b0001 << win) : 4'b0000;
        last_d   = push ? win : last_q;
        busy_d   = (state_d != IDLE) || (count_d != 5'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= 2'd3;
            ack_q      <= '0;
            timer_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            ack_q      <= ack_d;
            timer_q    <= timer_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_data[8*win +: 8];
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign fifo_count  = count_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_com_tx_scheduler.sv
// Directed bench for com_tx_scheduler with a small UART transmitter model that records each byte sent.
module tb_com_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [31:0] req_data = 32'b0;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_finish;
    logic [4:0]  fifo_count;
    logic        busy;
    logic        timeout_err;

    int          n_cmp = 0;
    int          n_mis = 0;
    bit          model_en = 1'b0;
    logic        force_fin = 1'b1;
    logic [7:0]  sent [$];
    int          tmo_cnt = 0;
    int          acks;

    always #5 clk = ~clk;

    com_tx_scheduler #(.FIFO_DEPTH(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_finish(tx_finish),
        .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err)
    );

    // Transmitter model: drops finish one cycle after seeing a start, stays busy three cycles.
    initial begin
        tx_finish = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (!model_en) begin
                tx_finish = force_fin;
            end else if (tx_start && tx_finish) begin
                sent.push_back(tx_data);
                tx_finish = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                tx_finish = 1'b1;
            end else begin
                tx_finish = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (timeout_err === 1'b1) tmo_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return busy === 1'b0;
            1:       return tx_start === 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input string tag, input int sel, input int max);
        int k = 0;
        while (!cond(sel) && k < max) begin
            tick;
            k++;
        end
        n_cmp++;
        assert (cond(sel)) else begin
            n_mis++;
            $error("FAIL %s observed=not reached expected=reached within %0d cycles", tag, max);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req = 4'b0;
        tick;
        tick;
        reset = 1'b0;
        sent.delete();
        tmo_cnt = 0;
    endtask

    initial begin
        // Reset state
        tick;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_txstart", 32'(tx_start), 32'h0);
        chk("rst_txdata", 32'(tx_data), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tmo", 32'(timeout_err), 32'h0);
        reset = 1'b0;
        model_en = 1'b1;

        // Single byte
        req = 4'b0001; req_data = 32'h0000005A;
        tick;
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_count", 32'(fifo_count), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick;
        chk("single_ack_gone", 32'(ack), 32'h0);
        chk("single_start", 32'(tx_start), 32'h1);
        chk("single_data", 32'(tx_data), 32'h5A);
        chk("single_count0", 32'(fifo_count), 32'h0);
        wait_cond("single_start_drop", 1, 10);
        chk("single_busy_frame", 32'(busy), 32'h1);
        wait_cond("single_idle", 0, 20);
        chk("single_sent_n", 32'(sent.size()), 32'd1);
        if (sent.size() > 0) chk("single_sent", 32'(sent[0]), 32'h5A);

        // Round robin
        do_reset;
        req = 4'b1111; req_data = 32'h43322110;
        tick; chk("rr_ack0", 32'(ack), 32'h1);
        tick; chk("rr_ack1", 32'(ack), 32'h2);
        tick; chk("rr_ack2", 32'(ack), 32'h4);
        tick; chk("rr_ack3", 32'(ack), 32'h8);
        tick; chk("rr_ack4", 32'(ack), 32'h1);
        req = 4'b0000;
        tick; chk("rr_ack_end", 32'(ack), 32'h0);
        wait_cond("rr_idle", 0, 200);
        chk("rr_sent_n", 32'(sent.size()), 32'd5);
        begin
            logic [7:0] rr_exp [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
            for (int i = 0; i < 5 && i < sent.size(); i++)
                chk($sformatf("rr_sent%0d", i), 32'(sent[i]), 32'(rr_exp[i]));
        end

        // Full FIFO
        do_reset;
        model_en = 1'b0; force_fin = 1'b0;
        acks = 0;
        req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            req_data = 32'(8'(8'h80 + k));
            tick;
            if (ack === 4'b0001) acks++;
        end
        chk("full_acks", 32'(acks), 32'd8);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_txstart", 32'(tx_start), 32'h0);
        req = 4'b0000;
        model_en = 1'b1;
        wait_cond("full_drain", 0, 300);
        chk("full_sent_n", 32'(sent.size()), 32'd8);
        for (int i = 0; i < 8 && i < sent.size(); i++)
            chk($sformatf("full_sent%0d", i), 32'(sent[i]), 32'(8'h80 + 2 * i));

        // Simultaneous push and pop at fifo_count=3
        do_reset;
        model_en = 1'b0; force_fin = 1'b0;
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            req_data = 32'(8'(8'hA0 + k / 2));
            tick;
        end
        req = 4'b0000;
        tick;
        chk("pp_count_before", 32'(fifo_count), 32'd3);
        force_fin = 1'b1;
        req = 4'b0001; req_data = 32'h000000B0;
        tick;
        chk("pp_count", 32'(fifo_count), 32'd3);
        chk("pp_start", 32'(tx_start), 32'h1);
        chk("pp_data", 32'(tx_data), 32'hA0);
        chk("pp_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        model_en = 1'b1;
        wait_cond("pp_drain", 0, 200);
        chk("pp_sent_n", 32'(sent.size()), 32'd4);
        begin
            logic [7:0] pp_exp [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
            for (int i = 0; i < 4 && i < sent.size(); i++)
                chk($sformatf("pp_sent%0d", i), 32'(sent[i]), 32'(pp_exp[i]));
        end

        // Timeout with tx_finish stuck high
        do_reset;
        model_en = 1'b0; force_fin = 1'b1;
        req = 4'b0001; req_data = 32'h000000C0;
        tick;
        req_data = 32'h000000C1;
        tick;
        chk("tmo_start", 32'(tx_start), 32'h1);
        chk("tmo_data", 32'(tx_data), 32'hC0);
        tick;
        req = 4'b0000;
        for (int k = 3; k <= 16; k++) tick;
        chk("tmo_start_c16", 32'(tx_start), 32'h1);
        chk("tmo_err_c16", 32'(timeout_err), 32'h0);
        chk("tmo_count", 32'(fifo_count), 32'd1);
        tick;
        chk("tmo_err", 32'(timeout_err), 32'h1);
        chk("tmo_start_drop", 32'(tx_start), 32'h0);
        chk("tmo_data_hold", 32'(tx_data), 32'hC0);
        tick;
        chk("tmo_err_pulse", 32'(timeout_err), 32'h0);
        chk("tmo_next_start", 32'(tx_start), 32'h1);
        chk("tmo_next_data", 32'(tx_data), 32'hC1);
        model_en = 1'b1;
        wait_cond("tmo_idle", 0, 50);
        chk("tmo_pulses", 32'(tmo_cnt), 32'd1);
        chk("tmo_sent_n", 32'(sent.size()), 32'd1);
        if (sent.size() > 0) chk("tmo_sent", 32'(sent[0]), 32'hC1);

        // Reset during WAIT_DONE with five bytes queued
        do_reset;
        model_en = 1'b0; force_fin = 1'b1;
        req = 4'b0001; req_data = 32'h000000D0;
        tick;
        req_data = 32'h000000D1;
        tick;
        force_fin = 1'b0;
        for (int k = 2; k <= 10; k++) tick;
        req = 4'b0000;
        chk("mid_count", 32'(fifo_count), 32'd5);
        chk("mid_start", 32'(tx_start), 32'h0);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_ack", 32'(ack), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_start", 32'(tx_start), 32'h0);
        chk("mid_rst_data", 32'(tx_data), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_count", 32'(fifo_count), 32'h0);
        chk("mid_rst_tmo", 32'(timeout_err), 32'h0);
        tick;
        tick;
        force_fin = 1'b1;
        reset = 1'b0;
        req = 4'b1000; req_data = 32'hE3000000;
        tick;
        chk("post_rst_ack", 32'(ack), 32'h8);
        chk("post_rst_count", 32'(fifo_count), 32'd1);
        req = 4'b0000;
        sent.delete();
        model_en = 1'b1;
        wait_cond("post_rst_idle", 0, 50);
        chk("post_rst_sent_n", 32'(sent.size()), 32'd1);
        if (sent.size() > 0) chk("post_rst_sent", 32'(sent[0]), 32'hE3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/com_tx_scheduler.md
COM_TX_SCHEDULER -- requirements
Module: com_tx_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, power of two from 2 to 16, byte entries in the transmit queue.
REQ-002 Parameter TIMEOUT_CYC, default 65535, clk cycles allowed per byte before the transfer is abandoned.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 req  input  4  per-requester byte-valid, level.
REQ-006 req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-007 ack  output  4  one-hot, one-cycle pulse: requester i byte accepted.
REQ-008 tx_start  output  1  start request to the UART transmitter (its isStart).
REQ-009 tx_data  output  8  byte to the transmitter (its data_raw); stable while tx_start=1.
REQ-010 tx_finish  input  1  transmitter isFinish; 1 = idle/done, 0 = frame in progress.
REQ-011 fifo_count  output  5  bytes queued, 0..FIFO_DEPTH.
REQ-012 busy  output  1  1 when state is not IDLE or fifo_count>0.
REQ-013 timeout_err  output  1  one-cycle pulse when a transfer is abandoned.

Function
REQ-014 Arbitration SHALL be round-robin over req: the search starts at (last_grant+1) mod 4, and last_grant updates on every grant.
REQ-015 A requester whose ack is high in the current cycle SHALL be masked from arbitration in that cycle.
REQ-016 A grant SHALL occur only when fifo_count<FIFO_DEPTH, with at most one grant per cycle.
REQ-017 On a grant, the winner's byte SHALL be written to the FIFO at that edge, and ack[winner] SHALL be 1 for exactly the next cycle.
REQ-018 The FIFO SHALL be first-in first-out, with wrap-around read and write pointers.
REQ-019 A simultaneous push and pop SHALL leave fifo_count unchanged, and the popped entry SHALL be the oldest.
REQ-020 When full, req SHALL be ignored with no ack and no overwrite.
REQ-021 A pop SHALL never occur when the FIFO is empty.
REQ-022 The FSM states SHALL be IDLE, START and WAIT_DONE.
REQ-023 IDLE: if fifo_count>0 and tx_finish=1, the FSM SHALL pop the head into tx_data, set tx_start=1, clear the timer and go to START.
REQ-024 IDLE: if tx_finish=0, the FSM SHALL wait in IDLE.
REQ-025 START: tx_start SHALL stay 1 until tx_finish=0 is sampled; then tx_start=0 and the FSM goes to WAIT_DONE.
REQ-026 WAIT_DONE: tx_start SHALL stay 0; when tx_finish=1 is sampled, the FSM goes to IDLE.
REQ-027 Back-to-back bytes SHALL be possible, with the next pop on the cycle after the WAIT_DONE->IDLE transition.
REQ-028 The timer SHALL increment every cycle in START and WAIT_DONE, saturate at TIMEOUT_CYC and clear on entry to START.
REQ-029 If the timer reaches TIMEOUT_CYC in START or WAIT_DONE, the FSM SHALL set tx_start=0, pulse timeout_err for one cycle, drop the byte and return to IDLE.
REQ-030 A timeout SHALL take priority over a tx_finish transition sampled in the same cycle.
REQ-031 tx_data SHALL change only on a pop.
REQ-032 fifo_count, ack, tx_start, tx_data, busy and timeout_err SHALL all be registered outputs.

Reset
REQ-033 While reset=1, asynchronously: FIFO empty, fifo_count=0, pointers=0, last_grant=3, state=IDLE, timer=0.
REQ-034 While reset=1, all outputs (ack, tx_start, tx_data, busy, timeout_err) SHALL be 0.
REQ-035 A reset mid-transfer SHALL abandon the byte and flush the FIFO with no ack.
REQ-036 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-037 Single byte: after reset, req=0001, req_data[7:0]=0x5A, transmitter model idle -> ack=0001 one cycle later, tx_start=1 with tx_data=0x5A, tx_start drops when tx_finish goes 0, busy=0 after tx_finish returns 1.
REQ-038 Round-robin: req=1111 held, distinct bytes 0x10,0x21,0x32,0x43 -> acks in order 0001,0010,0100,1000,0001, transmitted bytes in the same order.
REQ-039 Full: FIFO_DEPTH=8, tx_finish held 0, req=0001 -> exactly 8 acks, fifo_count=8, then no ack; release tx_finish -> drains in order.
REQ-040 Simultaneous push/pop: fifo_count=3, grant and pop in the same cycle -> fifo_count stays 3, oldest byte is sent.
REQ-041 Timeout: TIMEOUT_CYC=16, tx_finish stuck 1 after tx_start -> timeout_err pulses at cycle 16 of START, byte is dropped, next byte starts.
REQ-042 Reset mid-frame: assert reset while in WAIT_DONE with fifo_count=5 -> all outputs 0 immediately; after release, req=1000 alone gets ack=1000.
